// File: rtl/pipeline_hazard_unit_if.sv
// ID-stage <-> hazard unit bundle: the ID instruction descriptor going in,
// stall / forwarding selects / debug occupancy coming back.
interface pipeline_hazard_unit_if #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3
);
  localparam int SELW = $clog2(DEPTH + 1);

  // Handshake: ID offers an instruction whenever id_valid=1; the offer is
  // taken on a clock edge only when stall=0 (stall is the inverted ready).
  // flush_id kills the offer and also releases any stall it would cause.
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_rs_used;
  logic              id_rt_used;
  logic              id_wr;
  logic [REG_AW-1:0] id_rd;
  logic              id_is_load;
  logic              flush_id;
  logic              freeze;

  logic              stall;
  logic [SELW-1:0]   fwd_a_sel;
  logic [SELW-1:0]   fwd_b_sel;
  logic [SELW-1:0]   pending;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
    output id_wr, id_rd, id_is_load, flush_id, freeze,
    input  stall, fwd_a_sel, fwd_b_sel, pending
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
    input  id_wr, id_rd, id_is_load, flush_id, freeze,
    output stall, fwd_a_sel, fwd_b_sel, pending
  );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// Scoreboard-based load-use stall and forwarding-select unit for the MIPS ID stage.
// Optional macro HAZARD_STATS_EN adds saturating stall_cycles / fwd_events counters.
module pipeline_hazard_unit #(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  localparam int SELW    = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic reset,
  pipeline_hazard_unit_if.slave hz
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] fwd_events
`endif
);

  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0]             load_q,  load_d;
  logic [DEPTH-1:0][REG_AW-1:0] rd_q,    rd_d;

  logic [SELW:0]   op_a, op_b;
  logic            stall_w;
  logic            accept_w;
  logic [SELW-1:0] pending_w;

  // Returns {stall_contribution, select}; scanning oldest to youngest lets
  // the youngest matching producer overwrite older ones.
  function automatic logic [SELW:0] eval_op(
    input logic                         r_valid,
    input logic                         used,
    input logic [REG_AW-1:0]            r,
    input logic [DEPTH-1:0]             v,
    input logic [DEPTH-1:0]             ld,
    input logic [DEPTH-1:0][REG_AW-1:0] rd
  );
    logic            stl;
    logic [SELW-1:0] sel;
    stl = 1'b0;
    sel = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (v[k] && (rd[k] == r)) begin
        stl = ld[k] && (k < LOAD_LAT);
        sel = stl ? '0 : SELW'(k + 1);
      end
    end
    if (!r_valid || !used || (r == '0)) begin
      stl = 1'b0;
      sel = '0;
    end
    return {stl, sel};
  endfunction

  always_comb begin
    op_a = eval_op(hz.id_valid, hz.id_rs_used, hz.id_rs, valid_q, load_q, rd_q);
    op_b = eval_op(hz.id_valid, hz.id_rt_used, hz.id_rt, valid_q, load_q, rd_q);
    stall_w  = (op_a[SELW] | op_b[SELW]) & ~hz.flush_id;
    accept_w = hz.id_valid & hz.id_wr & (hz.id_rd != '0) & ~hz.flush_id & ~stall_w;
  end

  always_comb begin
    pending_w = '0;
    for (int k = 0; k < DEPTH; k++) begin
      pending_w = pending_w + SELW'(valid_q[k]);
    end
  end

  assign hz.stall     = stall_w;
  assign hz.fwd_a_sel = stall_w ? '0 : op_a[SELW-1:0];
  assign hz.fwd_b_sel = stall_w ? '0 : op_b[SELW-1:0];
  assign hz.pending   = pending_w;

  // Shift toward WB; a stalled or rejected ID slot enters as a bubble.
  always_comb begin
    valid_d = valid_q;
    load_d  = load_q;
    rd_d    = rd_q;
    if (!hz.freeze) begin
      valid_d = {valid_q[DEPTH-2:0], accept_w};
      load_d  = {load_q[DEPTH-2:0], accept_w & hz.id_is_load};
      rd_d    = {rd_q[DEPTH-2:0], hz.id_rd};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      load_q  <= '0;
      rd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      load_q  <= load_d;
      rd_q    <= rd_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] fwd_events_q,   fwd_events_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    fwd_events_d   = fwd_events_q;
    if (!hz.freeze && stall_w && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (!hz.freeze && ((hz.fwd_a_sel != '0) || (hz.fwd_b_sel != '0)) &&
        (fwd_events_q != '1)) begin
      fwd_events_d = fwd_events_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
      fwd_events_q   <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      fwd_events_q   <= fwd_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign fwd_events   = fwd_events_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench for pipeline_hazard_unit: default instance (DEPTH=3, LOAD_LAT=1)
// and a DEPTH=4 / LOAD_LAT=2 instance, checked through an expected-response queue.
module tb_pipeline_hazard_unit;
  localparam int W = 11;  // {dut, stall, a[2:0], b[2:0], pending[2:0]}

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipeline_hazard_unit_if #(.REG_AW(5), .DEPTH(3)) if0 ();
  pipeline_hazard_unit_if #(.REG_AW(5), .DEPTH(4)) if1 ();

`ifdef HAZARD_STATS_EN
  logic [31:0] sc0, fe0, sc1, fe1;
`endif

  pipeline_hazard_unit #(.REG_AW(5), .DEPTH(3), .LOAD_LAT(1)) dut0 (
    .clk(clk), .reset(reset), .hz(if0.slave)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(sc0), .fwd_events(fe0)
`endif
  );

  pipeline_hazard_unit #(.REG_AW(5), .DEPTH(4), .LOAD_LAT(2)) dut1 (
    .clk(clk), .reset(reset), .hz(if1.slave)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(sc1), .fwd_events(fe1)
`endif
  );

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           tests_run = 0;
  int           tests_failed = 0;

  task automatic idle_all();
    if0.id_valid = 0; if0.id_rs = 0; if0.id_rt = 0; if0.id_rs_used = 0;
    if0.id_rt_used = 0; if0.id_wr = 0; if0.id_rd = 0; if0.id_is_load = 0;
    if0.flush_id = 0; if0.freeze = 0;
    if1.id_valid = 0; if1.id_rs = 0; if1.id_rt = 0; if1.id_rs_used = 0;
    if1.id_rt_used = 0; if1.id_wr = 0; if1.id_rd = 0; if1.id_is_load = 0;
    if1.flush_id = 0; if1.freeze = 0;
  endtask

  // One clock cycle of stimulus on DUT d, plus the expected combinational response.
  task automatic cyc(input int d, input bit r, input bit v,
                     input logic [4:0] rs, input bit rsu,
                     input logic [4:0] rt, input bit rtu,
                     input bit wr, input logic [4:0] rd, input bit ld,
                     input bit fl, input bit fz,
                     input bit e_st, input int e_a, input int e_b, input int e_p,
                     input string nm);
    @(posedge clk);
    #1;
    idle_all();
    reset = r;
    if (d == 0) begin
      if0.id_valid = v; if0.id_rs = rs; if0.id_rs_used = rsu; if0.id_rt = rt;
      if0.id_rt_used = rtu; if0.id_wr = wr; if0.id_rd = rd; if0.id_is_load = ld;
      if0.flush_id = fl; if0.freeze = fz;
    end else begin
      if1.id_valid = v; if1.id_rs = rs; if1.id_rs_used = rsu; if1.id_rt = rt;
      if1.id_rt_used = rtu; if1.id_wr = wr; if1.id_rd = rd; if1.id_is_load = ld;
      if1.flush_id = fl; if1.freeze = fz;
    end
    exp_q.push_back({d[0], e_st, 3'(e_a), 3'(e_b), 3'(e_p)});
    name_q.push_back(nm);
  endtask

  task automatic bub(input int d, input bit fz, input int e_p, input string nm);
    cyc(d, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, fz, 0, 0, 0, e_p, nm);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    idle_all();
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  // Monitor: outputs are combinational, so every driven cycle presents a response.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e, act;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (e[W-1])
        act = {1'b1, if1.stall, if1.fwd_a_sel, if1.fwd_b_sel, if1.pending};
      else
        act = {1'b0, if0.stall, 1'b0, if0.fwd_a_sel, 1'b0, if0.fwd_b_sel,
               1'b0, if0.pending};
      tests_run++;
      if (act !== e) begin
        tests_failed++;
        $display("FAIL %s: got stall=%0b a=%0d b=%0d pend=%0d, want stall=%0b a=%0d b=%0d pend=%0d",
                 nm, act[9], act[8:6], act[5:3], act[2:0], e[9], e[8:6], e[5:3], e[2:0]);
      end
    end
  end

  initial begin
    idle_all();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    bub(0, 0, 0, "reset_state");
    bub(1, 0, 0, "reset_state1");

    // load-use on default depth
    cyc(0,0,1, 0,0, 0,0, 1,8,1, 0,0, 0,0,0,0, "lw8");
    cyc(0,0,1, 8,1,10,1, 1,9,0, 0,0, 1,0,0,1, "lu_stall");
    cyc(0,0,1, 8,1,10,1, 1,9,0, 0,0, 0,2,0,1, "lu_fwd_mem");
    bub(0, 0, 2, "t1_pend2");
    bub(0, 0, 1, "t1_pend1a");
    bub(0, 0, 1, "t1_pend1b");
    bub(0, 0, 0, "t1_drained");

    // ALU forwarding distance 1, 2 and out of range
    do_reset();
    cyc(0,0,1, 1,1, 2,1, 1,3,0, 0,0, 0,0,0,0, "add3");
    cyc(0,0,1, 3,1, 3,1, 1,4,0, 0,0, 0,1,1,1, "fwd_ex");
    do_reset();
    cyc(0,0,1, 1,1, 2,1, 1,3,0, 0,0, 0,0,0,0, "add3_b");
    bub(0, 0, 1, "gap1");
    cyc(0,0,1, 3,1, 3,1, 1,4,0, 0,0, 0,2,2,1, "fwd_mem");
    do_reset();
    cyc(0,0,1, 1,1, 2,1, 1,3,0, 0,0, 0,0,0,0, "add3_c");
    bub(0, 0, 1, "gap3a");
    bub(0, 0, 1, "gap3b");
    bub(0, 0, 1, "gap3c");
    cyc(0,0,1, 3,1, 3,1, 1,4,0, 0,0, 0,0,0,0, "fwd_none");

    // youngest producer wins
    do_reset();
    cyc(0,0,1, 0,0, 0,0, 1,5,0, 0,0, 0,0,0,0, "add5");
    cyc(0,0,1, 6,1, 7,1, 1,5,0, 0,0, 0,0,0,1, "or5");
    cyc(0,0,1, 0,0, 5,1, 0,0,0, 0,0, 0,0,1,2, "youngest");

    // register zero
    do_reset();
    cyc(0,0,1, 0,0, 0,0, 1,0,1, 0,0, 0,0,0,0, "ld_r0");
    cyc(0,0,1, 0,1, 0,1, 0,0,0, 0,0, 0,0,0,0, "use_r0");

    // flush beats stall, flushed instruction leaves no entry
    do_reset();
    cyc(0,0,1, 0,0, 0,0, 1,8,1, 0,0, 0,0,0,0, "lw8_f");
    cyc(0,0,1, 8,1, 0,0, 1,9,0, 1,0, 0,0,0,1, "flush_stall");
    cyc(0,0,1, 9,1, 0,0, 0,0,0, 0,0, 0,0,0,1, "flush_noentry");

    // freeze during load-use stall
    do_reset();
    cyc(0,0,1, 0,0, 0,0, 1,8,1, 0,0, 0,0,0,0, "lw8_z");
    cyc(0,0,1, 8,1, 0,0, 1,9,0, 0,1, 1,0,0,1, "frz1");
    cyc(0,0,1, 8,1, 0,0, 1,9,0, 0,1, 1,0,0,1, "frz2");
    cyc(0,0,1, 8,1, 0,0, 1,9,0, 0,1, 1,0,0,1, "frz3");
    cyc(0,0,1, 8,1, 0,0, 1,9,0, 0,0, 1,0,0,1, "frz_rel0");
    cyc(0,0,1, 8,1, 0,0, 1,9,0, 0,0, 0,2,0,1, "frz_rel1");

    // stall forces both selects to zero, WB forwarding
    do_reset();
    cyc(0,0,1, 1,1, 2,1, 1,3,0, 0,0, 0,0,0,0, "add3_m");
    cyc(0,0,1, 0,0, 0,0, 1,8,1, 0,0, 0,0,0,1, "lw8_m");
    cyc(0,0,1, 8,1, 3,1, 0,0,0, 0,0, 1,0,0,2, "stall_mask");
    cyc(0,0,1, 8,1, 3,1, 0,0,0, 0,0, 0,2,3,2, "fwd_wb");

    // DEPTH=4, LOAD_LAT=2
    do_reset();
    cyc(1,0,1, 0,0, 0,0, 1,8,1, 0,0, 0,0,0,0, "d4_lw8");
    cyc(1,0,1, 8,1, 0,0, 0,0,0, 0,0, 1,0,0,1, "d4_stall1");
    cyc(1,0,1, 8,1, 0,0, 0,0,0, 0,0, 1,0,0,1, "d4_stall2");
    cyc(1,0,1, 8,1, 0,0, 0,0,0, 0,0, 0,3,0,1, "d4_fwd");
    do_reset();
    cyc(1,0,1, 0,0, 0,0, 1,8,1, 0,0, 0,0,0,0, "d4_lw8_r");
    cyc(1,1,1, 8,1, 0,0, 0,0,0, 0,0, 1,0,0,1, "d4_rst_mid");
    cyc(1,0,1, 8,1, 0,0, 0,0,0, 0,0, 0,0,0,0, "d4_rst_clr");

    @(negedge clk);
    #1;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL queue_drain: %0d left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
